elem_search_engine: RTL and testbench

- Parametrised sequential search engine over an N-entry array of W-bit unsigned elements.
- The array is presented as a flat bus and captured on START. The engine then scans one element per clock and reports index, value, found flag and cycle count.
- Four modes: minimum, maximum, first-match-of-key, last-match-of-key.
- START/ACK handshake with a held DONE. This is the next-generation search block for the element-search datapath.

---
 rtl/elem_search_engine.sv | 172 +++++++++++++++++
 tb/tb_elem_search_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/elem_search_engine.sv
// Sequential element search engine: captures an N-entry array on start,
// scans one element per clock and reports min/max or first/last key match
// with its index, value, a found flag and the number of scan cycles.
module elem_search_engine #(
    parameter int W  = 7,
    parameter int N  = 10,
    parameter int IW = 4,
    parameter int CW = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            ack,
    input  logic [1:0]      mode,
    input  logic [W-1:0]    key,
    input  logic [N*W-1:0]  data_in,
    output logic            busy,
    output logic            done,
    output logic            found,
    output logic [IW-1:0]   index,
    output logic [W-1:0]    value,
    output logic [CW-1:0]   cycles
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_PTR = IW'(N - 1);
    localparam logic [CW-1:0] CYC_MAX  = {CW{1'b1}};

    state_t          state_reg, state_next;
    logic [W-1:0]    elem_in  [N];
    logic [W-1:0]    elem_reg [N];
    logic [IW-1:0]   ptr_reg, ptr_next;
    logic [1:0]      mode_reg, mode_next;
    logic [W-1:0]    key_reg, key_next;
    logic            found_reg, found_next;
    logic [IW-1:0]   index_reg, index_next;
    logic [W-1:0]    value_reg, value_next;
    logic [CW-1:0]   cycles_reg, cycles_next;

    logic [W-1:0]    cur_elem;
    logic            last_ptr;
    logic            capture;

    // Unpack the flat input bus into per-element lanes
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign elem_in[gi] = data_in[gi*W +: W];
        end
    endgenerate

    assign capture  = (state_reg == IDLE) && start;
    assign cur_elem = elem_reg[ptr_reg];
    assign last_ptr = (ptr_reg == LAST_PTR);

    // Snapshot the whole array when a search is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) elem_reg[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < N; i++) elem_reg[i] <= elem_in[i];
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            mode_reg   <= '0;
            key_reg    <= '0;
            found_reg  <= 1'b0;
            index_reg  <= '0;
            value_reg  <= '0;
            cycles_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            mode_reg   <= mode_next;
            key_reg    <= key_next;
            found_reg  <= found_next;
            index_reg  <= index_next;
            value_reg  <= value_next;
            cycles_reg <= cycles_next;
        end
    end

    // Next-state and datapath update: one element examined per COMPARE cycle
    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        mode_next   = mode_reg;
        key_next    = key_reg;
        found_next  = found_reg;
        index_next  = index_reg;
        value_next  = value_reg;
        cycles_next = cycles_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = COMPARE;
                    mode_next   = mode;
                    key_next    = key;
                    cycles_next = '0;
                    index_next  = '0;
                    if (!mode[1]) begin
                        // min/max seed with element 0, so scanning starts at 1
                        value_next = elem_in[0];
                        found_next = 1'b1;
                        ptr_next   = IW'(1);
                    end else begin
                        value_next = '0;
                        found_next = 1'b0;
                        ptr_next   = '0;
                    end
                end
            end
            COMPARE: begin
                cycles_next = (cycles_reg == CYC_MAX) ? cycles_reg : cycles_reg + CW'(1);
                ptr_next    = last_ptr ? ptr_reg : ptr_reg + IW'(1);
                if (last_ptr) state_next = DONE;
                case (mode_reg)
                    2'b00: begin
                        // strict compare keeps the lowest index on ties
                        if (cur_elem < value_reg) begin
                            index_next = ptr_reg;
                            value_next = cur_elem;
                        end
                    end
                    2'b01: begin
                        if (cur_elem > value_reg) begin
                            index_next = ptr_reg;
                            value_next = cur_elem;
                        end
                    end
                    2'b10: begin
                        if (cur_elem == key_reg) begin
                            found_next = 1'b1;
                            index_next = ptr_reg;
                            value_next = key_reg;
                            state_next = DONE;
                        end
                    end
                    default: begin
                        if (cur_elem == key_reg) begin
                            found_next = 1'b1;
                            index_next = ptr_reg;
                            value_next = key_reg;
                        end
                    end
                endcase
            end
            DONE: begin
                if (ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy   = (state_reg == COMPARE);
    assign done   = (state_reg == DONE);
    assign found  = found_reg;
    assign index  = index_reg;
    assign value  = value_reg;
    assign cycles = cycles_reg;

endmodule

// File: tb/tb_elem_search_engine.sv
// Directed, table-driven bench for elem_search_engine with hand-computed
// expectations plus sequences for handshake and reset corner cases.
module tb_elem_search_engine;

    localparam int W  = 7;
    localparam int N  = 10;
    localparam int IW = 4;
    localparam int CW = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            ack = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [W-1:0]    key = '0;
    logic [N*W-1:0]  data_in = '0;
    logic            busy, done, found;
    logic [IW-1:0]   index;
    logic [W-1:0]    value;
    logic [CW-1:0]   cycles;

    int pass_cnt = 0;
    int total_cnt = 0;

    elem_search_engine #(.W(W), .N(N), .IW(IW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack), .mode(mode),
        .key(key), .data_in(data_in), .busy(busy), .done(done),
        .found(found), .index(index), .value(value), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [N*W-1:0] data;
        logic [1:0]     mode;
        logic [W-1:0]   key;
        int             eidx;
        int             eval;
        int             efound;
        int             ecyc;
        int             elat;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [N*W-1:0] pk(input int e[N]);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(e[i]);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Start a search in IDLE, scramble inputs after E0, wait for done
    task automatic launch(input logic [N*W-1:0] d, input logic [1:0] m,
                          input logic [W-1:0] k, output int lat);
        @(negedge clk);
        data_in = d; mode = m; key = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        data_in = {N*W{1'b1}} ^ d;
        mode = ~m;
        key = ~k;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int hidx;
        launch(v.data, v.mode, v.key, lat);
        chk({v.name, " latency"}, lat, v.elat);
        chk({v.name, " done"}, int'(done), 1);
        chk({v.name, " index"}, int'(index), v.eidx);
        chk({v.name, " value"}, int'(value), v.eval);
        chk({v.name, " found"}, int'(found), v.efound);
        chk({v.name, " cycles"}, int'(cycles), v.ecyc);
        hidx = int'(index);
        repeat (2) @(posedge clk);
        #1;
        chk({v.name, " done held"}, int'(done), 1);
        chk({v.name, " index held"}, int'(index), v.eidx);
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
        chk({v.name, " done after ack"}, int'(done), 0);
        chk({v.name, " value after ack"}, int'(value), v.eval);
        $display("vec %s: mode=%0d key=%0d -> idx=%0d val=%0d found=%0d cyc=%0d lat=%0d",
                 v.name, v.mode, v.key, index, value, found, cycles, lat);
    endtask

    initial begin
        int arr_a[N] = '{40, 12, 90, 12, 7, 55, 7, 100, 3, 64};
        int arr_b[N] = '{5, 127, 9, 127, 0, 1, 2, 3, 4, 6};
        int arr_c[N] = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        logic [N*W-1:0] da, db, dc;
        int lat;

        da = pk(arr_a); db = pk(arr_b); dc = pk(arr_c);
        vecs[0]  = '{"min_a",     da, 2'b00, 7'd0,  8, 3,   1, 9,  9};
        vecs[1]  = '{"max_b",     db, 2'b01, 7'd0,  1, 127, 1, 9,  9};
        vecs[2]  = '{"first7_a",  da, 2'b10, 7'd7,  4, 7,   1, 5,  5};
        vecs[3]  = '{"last7_a",   da, 2'b11, 7'd7,  6, 7,   1, 10, 10};
        vecs[4]  = '{"first8_a",  da, 2'b10, 7'd8,  0, 0,   0, 10, 10};
        vecs[5]  = '{"max_a",     da, 2'b01, 7'd0,  7, 100, 1, 9,  9};
        vecs[6]  = '{"min_b",     db, 2'b00, 7'd0,  4, 0,   1, 9,  9};
        vecs[7]  = '{"last12_a",  da, 2'b11, 7'd12, 3, 12,  1, 10, 10};
        vecs[8]  = '{"first40_a", da, 2'b10, 7'd40, 0, 40,  1, 1,  1};
        vecs[9]  = '{"first64_a", da, 2'b10, 7'd64, 9, 64,  1, 10, 10};
        vecs[10] = '{"last8_a",   da, 2'b11, 7'd8,  0, 0,   0, 10, 10};
        vecs[11] = '{"min_ties",  dc, 2'b00, 7'd0,  0, 7,   1, 9,  9};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset found", int'(found), 0);
        chk("reset index", int'(index), 0);
        chk("reset value", int'(value), 0);
        chk("reset cycles", int'(cycles), 0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // start and ack pulsed during COMPARE are ignored
        @(negedge clk);
        data_in = da; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("busy after start", int'(busy), 1);
        repeat (3) @(posedge clk);
        @(negedge clk); start = 1'b1; ack = 1'b1; data_in = db; mode = 2'b01;
        @(posedge clk); #1; start = 1'b0; ack = 1'b0;
        lat = 4;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("pulse latency", lat, 9);
        chk("pulse index", int'(index), 8);
        chk("pulse value", int'(value), 3);
        chk("pulse cycles", int'(cycles), 9);
        $display("seq pulse_in_compare: idx=%0d val=%0d cyc=%0d lat=%0d", index, value, cycles, lat);

        // start and ack together in DONE: back to IDLE, no restart
        @(negedge clk); start = 1'b1; ack = 1'b1; mode = 2'b00; data_in = da;
        @(posedge clk); #1; start = 1'b0; ack = 1'b0;
        chk("start+ack done", int'(done), 0);
        chk("start+ack busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("no restart busy", int'(busy), 0);
        chk("no restart done", int'(done), 0);
        chk("idle holds index", int'(index), 8);
        chk("idle holds cycles", int'(cycles), 9);
        $display("seq start_ack_in_done: busy=%0d done=%0d idx=%0d", busy, done, index);

        // reset mid-COMPARE after four scan cycles
        @(negedge clk); data_in = da; mode = 2'b11; key = 7'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset cycles", int'(cycles), 4);
        reset = 1'b1;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort found", int'(found), 0);
        chk("abort index", int'(index), 0);
        chk("abort value", int'(value), 0);
        chk("abort cycles", int'(cycles), 0);
        $display("seq reset_mid_compare: busy=%0d found=%0d idx=%0d cyc=%0d", busy, found, index, cycles);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post-reset idle", int'(busy), 0);
        run_vec(vecs[0]);
        run_vec(vecs[3]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
